// File: rtl/obstacle_ctrl.sv
// Obstacle sprite sequencer: draw, hold, erase, advance across the VGA frame.
// Define OBSTACLE_WRAP_EN to loop the sprite back to START_X instead of stopping.
module obstacle_ctrl #(
    parameter int         FRAME_CYCLES    = 833333,
    parameter int         FRAMES_PER_STEP = 4,
    parameter logic [7:0] START_X         = 8'd10,
    parameter logic [6:0] START_Y         = 7'd58,
    parameter logic [7:0] END_X           = 8'd100,
    parameter logic [2:0] OBS_COLOUR      = 3'd2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       stop,
    output logic       plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       busy,
    output logic       done
);

    localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(FRAMES_PER_STEP - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        WAIT,
        ERASE,
        MOVE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    pos_x;
    logic [3:0]    pix_cnt;
    logic [FW-1:0] frame_cnt;
    logic [SW-1:0] step_cnt;

    logic frame_wrap;
    logic step_last;
    logic pix_last;
    logic at_end;
    logic scan;

    assign frame_wrap = (frame_cnt == FRAME_LAST);
    assign step_last  = (step_cnt == STEP_LAST);
    assign pix_last   = (pix_cnt == 4'hF);
    assign at_end     = (pos_x == END_X);

    always_comb begin
        state_nx = state;
        if (stop) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: if (start) state_nx = DRAW;
                DRAW:  if (pix_last) state_nx = WAIT;
                WAIT:  if (frame_wrap && step_last) state_nx = ERASE;
                ERASE: if (pix_last) state_nx = MOVE;
`ifdef OBSTACLE_WRAP_EN
                MOVE:  state_nx = DRAW;
`else
                MOVE:  state_nx = at_end ? DONE : DRAW;
`endif
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            pos_x     <= START_X;
            pix_cnt   <= '0;
            frame_cnt <= '0;
            step_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (stop) begin
                pix_cnt   <= '0;
                frame_cnt <= '0;
                step_cnt  <= '0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            pos_x     <= START_X;
                            pix_cnt   <= '0;
                            frame_cnt <= '0;
                            step_cnt  <= '0;
                        end
                    end
                    DRAW: begin
                        pix_cnt <= pix_cnt + 4'd1;
                        if (pix_last) begin
                            frame_cnt <= '0;
                            step_cnt  <= '0;
                        end
                    end
                    WAIT: begin
                        if (frame_wrap) begin
                            frame_cnt <= '0;
                            // step_cnt is cleared explicitly since the step count need not be a power of two
                            if (step_last) begin
                                step_cnt <= '0;
                                pix_cnt  <= '0;
                            end else begin
                                step_cnt <= step_cnt + SW'(1);
                            end
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                    ERASE: pix_cnt <= pix_cnt + 4'd1;
                    MOVE: begin
                        pix_cnt <= '0;
                        if (!at_end) begin
                            pos_x <= pos_x + 8'd1;
                        end else begin
`ifdef OBSTACLE_WRAP_EN
                            pos_x <= START_X;
`else
                            pos_x <= pos_x;
`endif
                        end
                    end
                    default: begin
                        pix_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        scan   = (state == DRAW) || (state == ERASE);
        plot   = scan;
        colour = (state == DRAW) ? OBS_COLOUR : 3'd0;
        x      = pos_x;
        y      = START_Y;
        if (scan) begin
            x = pos_x + {6'd0, pix_cnt[1:0]};
            y = START_Y + {5'd0, pix_cnt[3:2]};
        end
        busy = (state == DRAW) || (state == WAIT) ||
               (state == ERASE) || (state == MOVE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_obstacle_ctrl.sv
// Scoreboard bench for obstacle_ctrl with a shortened frame time.
// Expected output words are queued per cycle and popped after each edge.
module tb_obstacle_ctrl;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    logic [20:0] exp_q[$];

`ifdef OBSTACLE_WRAP_EN
    localparam int END_STOP = 139;
`else
    localparam int END_STOP = -1;
`endif

    obstacle_ctrl #(
        .FRAME_CYCLES   (4),
        .FRAMES_PER_STEP(2),
        .START_X        (8'd10),
        .START_Y        (7'd58),
        .END_X          (8'd12),
        .OBS_COLOUR     (3'd2)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .start (start),
        .stop  (stop),
        .plot  (plot),
        .x     (x),
        .y     (y),
        .colour(colour),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    wire [20:0] obs = {plot, x, y, colour, busy, done};

    function automatic logic [20:0] pk(input logic p, input logic [7:0] px,
                                      input logic [6:0] py, input logic [2:0] c,
                                      input logic b, input logic d);
        return {p, px, py, c, b, d};
    endfunction

    task automatic check(input string tag, input logic [20:0] got,
                         input logic [20:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got p=%0d x=%0d y=%0d c=%0d b=%0d d=%0d, want p=%0d x=%0d y=%0d c=%0d b=%0d d=%0d",
                     tag, got[20], got[19:12], got[11:5], got[4:2], got[1], got[0],
                     want[20], want[19:12], want[11:5], want[4:2], want[1], want[0]);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h want entry", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic push_idle(input int n, input logic [7:0] px);
        for (int i = 0; i < n; i++) exp_q.push_back(pk(0, px, 7'd58, 0, 0, 0));
    endtask

    task automatic push_done(input int n, input logic [7:0] px);
        for (int i = 0; i < n; i++) exp_q.push_back(pk(0, px, 7'd58, 0, 0, 1));
    endtask

    task automatic push_wait(input int n, input logic [7:0] px);
        for (int i = 0; i < n; i++) exp_q.push_back(pk(0, px, 7'd58, 0, 1, 0));
    endtask

    task automatic push_scan(input logic [7:0] px, input logic [2:0] c, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(pk(1, px + 8'(i % 4), 7'd58 + 7'(i / 4), c, 1, 0));
    endtask

    task automatic push_step(input logic [7:0] px);
        push_scan(px, 3'd2, 16);
        push_wait(8, px);
        push_scan(px, 3'd0, 16);
        push_wait(1, px);
    endtask

    task automatic push_run();
        push_step(8'd10);
        push_step(8'd11);
        push_step(8'd12);
`ifdef OBSTACLE_WRAP_EN
        push_scan(8'd10, 3'd2, 16);
        push_idle(2, 8'd10);
`else
        push_done(3, 8'd12);
`endif
    endtask

    task automatic run_q(input string tag, input int s0, input int s1,
                         input int s2, input int p);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            start = (k == s0) || (k == s1) || (k == s2);
            stop  = (k == p);
            tick($sformatf("%s[%0d]", tag, k));
            k++;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: sim time %0t exceeded bound", $time);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("reset", obs, pk(0, 8'd10, 7'd58, 0, 0, 0));
        @(negedge clock);
        resetn = 1'b1;

        push_idle(6, 8'd10);
        run_q("idle", -1, -1, -1, -1);

        push_run();
        run_q("run1", 0, -1, -1, END_STOP);

        push_run();
        run_q("run2", 0, 18, 30, END_STOP);

        push_scan(8'd10, 3'd2, 6);
        push_idle(3, 8'd10);
        run_q("stop", 0, -1, -1, 6);

        push_idle(3, 8'd10);
        run_q("both", 0, -1, -1, 0);

        push_scan(8'd10, 3'd2, 16);
        push_wait(3, 8'd10);
        push_idle(2, 8'd10);
        run_q("restart", 0, -1, -1, 19);

        push_scan(8'd10, 3'd2, 3);
        run_q("pre_rst", 0, -1, -1, -1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst", obs, pk(0, 8'd10, 7'd58, 0, 0, 0));
        @(negedge clock);
        resetn = 1'b1;
        push_idle(3, 8'd10);
        run_q("post_rst", -1, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/obstacle_ctrl.md
# obstacle_ctrl

Controller that sequences a single 4x4 obstacle sprite across the VGA frame buffer: draw, hold for a configurable number of frames, erase, advance one pixel, repeat. It owns the frame-rate timing and the pixel-scan counter. It drives the VGA adapter's plot/x/y/colour write port directly, replacing ad-hoc next/finish coupling with an explicit state machine and start/stop/done handshake.

## Interface
Parameters:
- FRAME_CYCLES, 833333: clock cycles per display frame (50 MHz / 60).
- FRAMES_PER_STEP, 4: frames the sprite is held before each one-pixel move.
- START_X, 10: left column of the sprite at start (8 bits).
- START_Y, 58: top row of the sprite (7 bits, fixed for the whole run).
- END_X, 100: last left column drawn. Constraint: START_X ≤ END_X ≤ 156.
- OBS_COLOUR, 3'd2: sprite colour. Erase colour is fixed at 3'd0.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin a run. Sampled only in IDLE or DONE.
- stop  in  1  synchronous abort. Accepted in any state.
- plot  out  1  VGA write enable.
- x  out  8  pixel column.
- y  out  7  pixel row.
- colour  out  3  pixel colour.
- busy  out  1  high in DRAW, WAIT, ERASE and MOVE.
- done  out  1  high in DONE.

## Operation
- States: IDLE, DRAW, WAIT, ERASE, MOVE, DONE.
- Internal registers:
  - pos_x: 8 bits.
  - pix_cnt: 4 bits.
  - frame_cnt: width clog2(FRAME_CYCLES).
  - step_cnt: width clog2(FRAMES_PER_STEP).
- IDLE/DONE transitions:
  - start=1 moves to DRAW.
  - On that transition: pos_x←START_X, pix_cnt←0, frame_cnt←0, step_cnt←0.
- DRAW:
  - plot=1, colour=OBS_COLOUR.
  - x=pos_x+pix_cnt[1:0], y=START_Y+pix_cnt[3:2]. Addition is unsigned and never overflows given the parameter constraints.
  - pix_cnt increments every cycle.
  - When pix_cnt=15: go to WAIT and clear frame_cnt and step_cnt.
- WAIT:
  - plot=0.
  - frame_cnt counts 0..FRAME_CYCLES-1 and wraps. Each wrap increments step_cnt.
  - When frame_cnt wraps with step_cnt=FRAMES_PER_STEP-1: go to ERASE with pix_cnt=0.
  - WAIT therefore lasts exactly FRAME_CYCLES×FRAMES_PER_STEP cycles.
- ERASE: same scan as DRAW at the same pos_x, with colour=0. At pix_cnt=15 go to MOVE.
- MOVE: plot=0, one cycle.
  - If pos_x==END_X: go to DONE.
  - Otherwise: pos_x←pos_x+1, pix_cnt←0, go to DRAW.
- stop=1 in any state forces IDLE on the next edge and clears pix_cnt and the frame/step counters. pos_x is held.
  - stop and start together: stop wins.
  - A stop during DRAW leaves a partially drawn sprite. Clearing it is the caller's job.
- start while busy is ignored.
- Outputs outside DRAW/ERASE: plot=0, colour=0, x=pos_x, y=START_Y.
- Reset values: state IDLE, pos_x=START_X; plot=0, x=START_X, y=START_Y, colour=0, busy=0, done=0.

## Timing
- All outputs are decoded combinationally from registered state, pos_x and pix_cnt. There is no added pipeline stage.
- First DRAW pixel appears in the cycle after the edge that samples start=1.
- Per-step period: 16 (DRAW) + FRAME_CYCLES×FRAMES_PER_STEP (WAIT) + 16 (ERASE) + 1 (MOVE) cycles.
- done rises one cycle after the final MOVE. busy falls in the same cycle.
- Reset deassertion is asynchronous-assert, synchronous-release (external synchronizer). The first active edge after release sees IDLE.

## Configuration
- OBSTACLE_WRAP_EN defined: MOVE with pos_x==END_X sets pos_x←START_X and goes to DRAW. The obstacle loops indefinitely, DONE is unreachable and done stays 0.
- OBSTACLE_WRAP_EN undefined: the run terminates in DONE as described above.

## Test plan
All scenarios use FRAME_CYCLES=4, FRAMES_PER_STEP=2, START_X=10, START_Y=58, END_X=12, OBS_COLOUR=2.

1. Reset pulse, then idle → plot=0, x=10, y=58, colour=0, busy=0, done=0 held indefinitely.
2. One-cycle start pulse → next 16 cycles plot=1, colour=2, pixels from (10,58) to (13,61) in row-major order; busy=1.
3. Continue run → 8 cycles plot=0, then 16 cycles colour=0 at the same pixels, 1 MOVE cycle, then DRAW at (11,58). Period is 41 cycles.
4. Run to completion → after ERASE at x=12, DONE: done=1, busy=0.
   - With OBSTACLE_WRAP_EN: DRAW restarts at (10,58) and done stays 0.
5. stop asserted on the 6th DRAW cycle → next cycle IDLE, plot=0. A new start draws from (10,58). start and stop together → IDLE.
6. start pulsed during WAIT and ERASE → no effect on the sequence. start in DONE → new run from x=10.
